// File: rtl/input_debounce_bank_if.sv
// input_debounce_bank_if
// Groups the change-report handshake of input_debounce_bank.
//   event_valid   : producer -> consumer, a change report is presented
//   event_ready   : consumer -> producer, the report is accepted this cycle
//   event_channel : producer -> consumer, index of the reported channel
//   event_level   : producer -> consumer, current level of that channel
// CH_W must equal max(1, clog2(CHANNELS)) of the attached bank.
interface input_debounce_bank_if #(
  parameter int CH_W = 4
);
  logic            event_valid;
  logic            event_ready;
  logic [CH_W-1:0] event_channel;
  logic            event_level;

  modport master (
    output event_valid,
    output event_channel,
    output event_level,
    input  event_ready
  );

  modport slave (
    input  event_valid,
    input  event_channel,
    input  event_level,
    output event_ready
  );
endinterface

// File: rtl/input_debounce_bank.sv
// input_debounce_bank
// A bank of independent switch/sensor debouncers with a shared change-report
// channel.  Each raw pin is optionally inverted, passed through a 2-flop
// synchroniser, sampled into a DEPTH-deep history on every prescaler tick,
// and its level only moves once the whole history agrees.  Level changes are
// latched as per-channel pending bits and reported one at a time, lowest
// channel first, over a valid/ready handshake.
//
// Ports
//   clk     : system clock, rising edge
//   reset   : synchronous, active-high; clears all state
//   raw_in  : [CHANNELS] asynchronous raw pins
//   level   : [CHANNELS] debounced, registered active-high state
//   rise    : [CHANNELS] one-cycle pulse on a 0->1 level change
//   fall    : [CHANNELS] one-cycle pulse on a 1->0 level change
//   evt     : change-report handshake (master side)
module input_debounce_bank #(
  parameter int CHANNELS   = 14,
  parameter int DEPTH      = 8,
  parameter int SAMPLE_DIV = 1,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [CHANNELS-1:0]    raw_in,
  output logic [CHANNELS-1:0]    level,
  output logic [CHANNELS-1:0]    rise,
  output logic [CHANNELS-1:0]    fall,
  input_debounce_bank_if.master  evt
);

  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int PW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(SAMPLE_DIV - 1);

  // Input conditioning
  logic [CHANNELS-1:0] raw_act_s;
  logic [CHANNELS-1:0] sync1_r;
  logic [CHANNELS-1:0] sync2_r;

  // Sampling
  logic [PW-1:0]       presc_r;
  logic                tick_s;
  logic [DEPTH-1:0]    hist_r [CHANNELS];
  logic [CHANNELS-1:0] all1_r;
  logic [CHANNELS-1:0] all0_r;

  // Debounced level
  logic [CHANNELS-1:0] level_r;
  logic [CHANNELS-1:0] level_s;
  logic [CHANNELS-1:0] set_s;
  logic [CHANNELS-1:0] clr_s;
  logic [CHANNELS-1:0] rise_r;
  logic [CHANNELS-1:0] fall_r;

  // Change reporting
  logic [CHANNELS-1:0] pending_r;
  logic [CHANNELS-1:0] pending_s;
  logic [CHANNELS-1:0] accept_vec_s;
  logic                accept_s;
  logic                found_s;
  logic [CW-1:0]       pick_s;
  logic                pick_level_s;
  logic                cur_level_s;
  logic                ev_valid_r;
  logic [CW-1:0]       ev_chan_r;
  logic                ev_level_r;

  // Normalise polarity so everything downstream is active-high.
  assign raw_act_s = (ACTIVE_LOW != 0) ? ~raw_in : raw_in;

  // Two-flop synchroniser for the asynchronous pins.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_r <= '0;
      sync2_r <= '0;
    end else begin
      sync1_r <= raw_act_s;
      sync2_r <= sync1_r;
    end
  end

  // Prescaler: tick on the terminal count, then wrap to zero.
  assign tick_s = (presc_r == PRESC_LAST);

  // Prescaler counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      presc_r <= '0;
    end else if (tick_s) begin
      presc_r <= '0;
    end else begin
      presc_r <= presc_r + PW'(1'b1);
    end
  end

  // Per-channel sample history, shifted once per tick.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < CHANNELS; i++) begin
        hist_r[i] <= '0;
      end
    end else if (tick_s) begin
      for (int i = 0; i < CHANNELS; i++) begin
        hist_r[i] <= {hist_r[i][DEPTH-2:0], sync2_r[i]};
      end
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        hist_r[i] <= hist_r[i];
      end
    end
  end

  // Registered agreement flags.  The level only moves on a tick, so with a
  // divided sample rate it lands exactly one sample period after the history
  // fills; at full rate this register adds the single cycle of lag.
  always_ff @(posedge clk) begin
    if (reset) begin
      all1_r <= '0;
      all0_r <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        all1_r[i] <= &hist_r[i];
        all0_r[i] <= ~|hist_r[i];
      end
    end
  end

  // Next level: move to 1 / 0 only on full agreement, otherwise hold.
  assign set_s   = {CHANNELS{tick_s}} & all1_r & ~level_r;
  assign clr_s   = {CHANNELS{tick_s}} & all0_r &  level_r;
  assign level_s = (level_r | set_s) & ~clr_s;

  // Level register with edge pulses aligned to the first cycle of the new level.
  always_ff @(posedge clk) begin
    if (reset) begin
      level_r <= '0;
      rise_r  <= '0;
      fall_r  <= '0;
    end else begin
      level_r <= level_s;
      rise_r  <= set_s;
      fall_r  <= clr_s;
    end
  end

  assign accept_s = ev_valid_r & evt.event_ready;

  // Lowest pending channel, live level of the presented channel, and the
  // pending-bit update.  A change in the same cycle as acceptance wins, so
  // the channel is reported again with its new level.
  always_comb begin
    accept_vec_s = '0;
    found_s      = 1'b0;
    pick_s       = '0;
    pick_level_s = 1'b0;
    cur_level_s  = 1'b0;
    // Descending scan so the lowest index is the last one written.
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (pending_r[i]) begin
        found_s      = 1'b1;
        pick_s       = CW'(i);
        pick_level_s = level_s[i];
      end else begin
        found_s      = found_s;
      end
      if (ev_chan_r == CW'(i)) begin
        accept_vec_s[i] = accept_s;
        cur_level_s     = level_s[i];
      end else begin
        accept_vec_s[i] = 1'b0;
      end
    end
    pending_s = (pending_r & ~accept_vec_s) | set_s | clr_s;
  end

  // Report register.  The channel is frozen while presented; the level of
  // that same channel follows any further change so that repeated changes
  // coalesce into one report carrying the latest level.  A new report is
  // loaded only from the idle state, which guarantees an idle cycle after
  // every acceptance.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending_r  <= '0;
      ev_valid_r <= 1'b0;
      ev_chan_r  <= '0;
      ev_level_r <= 1'b0;
    end else begin
      pending_r <= pending_s;
      if (!ev_valid_r) begin
        if (found_s) begin
          ev_valid_r <= 1'b1;
          ev_chan_r  <= pick_s;
          ev_level_r <= pick_level_s;
        end else begin
          ev_valid_r <= 1'b0;
          ev_chan_r  <= ev_chan_r;
          ev_level_r <= ev_level_r;
        end
      end else if (accept_s) begin
        ev_valid_r <= 1'b0;
        ev_chan_r  <= ev_chan_r;
        ev_level_r <= ev_level_r;
      end else begin
        ev_valid_r <= 1'b1;
        ev_chan_r  <= ev_chan_r;
        ev_level_r <= cur_level_s;
      end
    end
  end

  assign level             = level_r;
  assign rise              = rise_r;
  assign fall              = fall_r;
  assign evt.event_valid   = ev_valid_r;
  assign evt.event_channel = ev_chan_r;
  assign evt.event_level   = ev_level_r;

endmodule

// File: tb/tb_input_debounce_bank.sv
// tb_input_debounce_bank
// Bench for input_debounce_bank (4 channels, depth 4, active-low pins).
// A reference model derives every expected output from the behavioural
// rules: a level is decided by the window of DEPTH raw samples taken 4..7
// edges earlier, reports go out lowest-pending-first with a frozen channel.
// A second instance with SAMPLE_DIV=5 checks the divided-rate latency.
module tb_input_debounce_bank;

  localparam int CH = 4;
  localparam int DP = 4;
  localparam int DL = DP + 4;

  logic          clk;
  logic          reset;
  logic [CH-1:0] raw_in;
  logic [CH-1:0] level, rise, fall;
  logic          reset5;
  logic [CH-1:0] raw5;
  logic [CH-1:0] level5, rise5, fall5;

  input_debounce_bank_if #(.CH_W(2)) evt_if ();
  input_debounce_bank_if #(.CH_W(2)) evt5_if ();

  input_debounce_bank #(
    .CHANNELS(CH), .DEPTH(DP), .SAMPLE_DIV(1), .ACTIVE_LOW(1)
  ) u_dut (
    .clk(clk), .reset(reset), .raw_in(raw_in),
    .level(level), .rise(rise), .fall(fall), .evt(evt_if.master)
  );

  input_debounce_bank #(
    .CHANNELS(CH), .DEPTH(DP), .SAMPLE_DIV(5), .ACTIVE_LOW(1)
  ) u_dut5 (
    .clk(clk), .reset(reset5), .raw_in(raw5),
    .level(level5), .rise(rise5), .fall(fall5), .evt(evt5_if.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // ---------------- reference model ----------------
  logic [CH-1:0] dl [DL];   // dl[k]: active-high pin value sampled k edges ago
  logic [CH-1:0] m_level = '0;
  logic [CH-1:0] m_rise  = '0;
  logic [CH-1:0] m_fall  = '0;
  logic [CH-1:0] m_pend  = '0;
  logic          m_valid = 1'b0;
  int            m_chan  = 0;

  function automatic int lowest(input logic [CH-1:0] v);
    for (int i = 0; i < CH; i++) begin
      if (v[i]) return i;
    end
    return 0;
  endfunction

  task automatic model_step();
    logic [CH-1:0] old_lvl, all1, all0;
    logic          acc;
    if (reset) begin
      for (int k = 0; k < DL; k++) dl[k] = '0;
      m_level = '0; m_rise = '0; m_fall = '0; m_pend = '0;
      m_valid = 1'b0; m_chan = 0;
    end else begin
      for (int k = DL - 1; k > 0; k--) dl[k] = dl[k-1];
      dl[0] = ~raw_in;
      all1 = '1;
      all0 = '1;
      for (int k = 4; k < DL; k++) begin
        all1 = all1 & dl[k];
        all0 = all0 & ~dl[k];
      end
      old_lvl = m_level;
      m_level = (old_lvl | all1) & ~all0;
      m_rise  = m_level & ~old_lvl;
      m_fall  = old_lvl & ~m_level;
      acc = m_valid && evt_if.event_ready;
      if (!m_valid) begin
        if (m_pend != '0) begin
          m_valid = 1'b1;
          m_chan  = lowest(m_pend);
        end
      end else if (acc) begin
        m_valid = 1'b0;
        m_pend[m_chan] = 1'b0;
      end
      m_pend = m_pend | m_rise | m_fall;
    end
  endtask

  initial begin
    for (int k = 0; k < DL; k++) dl[k] = '0;
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  // Accepted-report log taken from the DUT handshake (pre-edge values).
  int   acc_total = 0;
  int   acc_cnt [CH];
  logic acc_lvl [CH];
  initial begin
    for (int i = 0; i < CH; i++) begin acc_cnt[i] = 0; acc_lvl[i] = 1'b0; end
    forever begin
      @(posedge clk);
      if (!reset && evt_if.event_valid && evt_if.event_ready) begin
        acc_total++;
        acc_cnt[evt_if.event_channel]++;
        acc_lvl[evt_if.event_channel] = evt_if.event_level;
      end
    end
  end

  // Per-cycle comparison against the model.
  initial begin
    forever begin
      @(negedge clk);
      chk("level", level, m_level);
      chk("rise", rise, m_rise);
      chk("fall", fall, m_fall);
      chk("rise_and_fall", rise & fall, 4'h0);
      chk("event_valid", evt_if.event_valid, m_valid);
      if (m_valid) begin
        chk("event_channel", evt_if.event_channel, m_chan);
        chk("event_level", evt_if.event_level, m_level[m_chan]);
      end
    end
  end

  // ---------------- stimulus ----------------
  int snap;
  initial begin
    reset = 1'b1; raw_in = 4'hF; evt_if.event_ready = 1'b0;
    reset5 = 1'b1; raw5 = 4'hF; evt5_if.event_ready = 1'b1;
    cyc(3);
    chk("reset_level", level, 4'h0);
    chk("reset_valid", evt_if.event_valid, 1'b0);
    reset = 1'b0;
    cyc(2);

    // Single channel activation: level 7 edges after the sampling edge.
    raw_in[2] = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      cyc(1);
      if (k == 7) chk("ch2_level_before", level[2], 1'b0);
      if (k == 8) begin
        chk("ch2_level_after", level[2], 1'b1);
        chk("ch2_rise", rise[2], 1'b1);
      end
      if (k == 9) begin
        chk("ch2_rise_gone", rise[2], 1'b0);
        chk("ch2_ev_valid", evt_if.event_valid, 1'b1);
        chk("ch2_ev_chan", evt_if.event_channel, 2'd2);
        chk("ch2_ev_level", evt_if.event_level, 1'b1);
      end
    end
    evt_if.event_ready = 1'b1;
    cyc(1);
    evt_if.event_ready = 1'b0;
    cyc(2);

    // Bouncing input never settles.
    for (int t = 0; t < 40; t++) begin
      if (t % 2 == 0) raw_in[1] = ~raw_in[1];
      cyc(1);
    end
    raw_in[1] = 1'b1;
    cyc(8);
    chk("bounce_level", level[1], 1'b0);
    chk("bounce_no_event", evt_if.event_valid, 1'b0);

    // Two simultaneous changes: lowest first, held, idle gap, then next.
    raw_in[3] = 1'b0; raw_in[0] = 1'b0;
    cyc(12);
    chk("pair_valid", evt_if.event_valid, 1'b1);
    chk("pair_first", evt_if.event_channel, 2'd0);
    cyc(3);
    chk("pair_held", evt_if.event_channel, 2'd0);
    evt_if.event_ready = 1'b1;
    cyc(1);
    chk("pair_idle", evt_if.event_valid, 1'b0);
    evt_if.event_ready = 1'b0;
    cyc(1);
    chk("pair_second_valid", evt_if.event_valid, 1'b1);
    chk("pair_second", evt_if.event_channel, 2'd3);
    evt_if.event_ready = 1'b1;
    cyc(1);
    evt_if.event_ready = 1'b0;
    cyc(2);

    // Activate then release before acceptance: one coalesced report.
    snap = acc_cnt[1];
    raw_in[1] = 1'b0;
    cyc(12);
    raw_in[1] = 1'b1;
    cyc(18);
    evt_if.event_ready = 1'b1;
    cyc(5);
    evt_if.event_ready = 1'b0;
    chk("coalesce_count", acc_cnt[1] - snap, 1);
    chk("coalesce_level", acc_lvl[1], 1'b0);

    // Randomised pins and consumer back-pressure.
    for (int t = 0; t < 700; t++) begin
      for (int b = 0; b < CH; b++) begin
        if ($urandom_range(0, 9) == 0) raw_in[b] = ~raw_in[b];
      end
      evt_if.event_ready = ($urandom_range(0, 3) != 0);
      cyc(1);
    end
    raw_in = 4'hF;
    evt_if.event_ready = 1'b1;
    cyc(30);

    // Reset in the middle of a presented report.
    evt_if.event_ready = 1'b0;
    raw_in = 4'h0;
    cyc(10);
    chk("mid_reset_valid_before", evt_if.event_valid, 1'b1);
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    chk("mid_reset_level", level, 4'h0);
    chk("mid_reset_rise", rise, 4'h0);
    chk("mid_reset_fall", fall, 4'h0);
    chk("mid_reset_valid", evt_if.event_valid, 1'b0);
    chk("mid_reset_chan", evt_if.event_channel, 2'd0);
    chk("mid_reset_evlvl", evt_if.event_level, 1'b0);
    snap = acc_total;
    evt_if.event_ready = 1'b1;
    cyc(25);
    chk("redetect_level", level, 4'hF);
    chk("redetect_reports", acc_total - snap, 4);

    // Divided sample rate: first sampling tick is edge 5, level at edge 25.
    reset5 = 1'b0;
    cyc(2);
    raw5[0] = 1'b0;
    cyc(22);
    chk("div5_level_before", level5[0], 1'b0);
    cyc(1);
    chk("div5_level_after", level5[0], 1'b1);
    chk("div5_rise", rise5[0], 1'b1);
    chk("div5_fall", fall5, 4'h0);
    cyc(1);
    chk("div5_ev_valid", evt5_if.event_valid, 1'b1);
    chk("div5_ev_chan", evt5_if.event_channel, 2'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/input_debounce_bank.md
INPUT_DEBOUNCE_BANK -- requirements
Module: input_debounce_bank

Interface
REQ-001 The block SHALL have one clock and one reset: reset is synchronous and active-high.
REQ-002 The block SHALL have parameter CHANNELS, default 14, giving the number of independent input channels (range 1..64).
REQ-003 The block SHALL have parameter DEPTH, default 8, giving the consecutive agreeing samples needed to change a level (range 2..32).
REQ-004 The block SHALL have parameter SAMPLE_DIV, default 1, meaning one sample tick every SAMPLE_DIV clk cycles (range 1..65535).
REQ-005 The block SHALL have parameter ACTIVE_LOW, default 1; when 1, every raw input is inverted before synchronisation.
REQ-006 clk  input  1  system clock, all logic on rising edge.
REQ-007 reset  input  1  synchronous, active-high.
REQ-008 raw_in  input  CHANNELS  asynchronous switch/sensor pins.
REQ-009 level  output  CHANNELS  debounced, registered active-high state per channel.
REQ-010 rise  output  CHANNELS  one-cycle pulse per channel on a 0->1 level change.
REQ-011 fall  output  CHANNELS  one-cycle pulse per channel on a 1->0 level change.
REQ-012 event_valid  output  1  a change report is presented.
REQ-013 event_ready  input  1  consumer accepts the report.
REQ-014 event_channel  output  max(1,clog2(CHANNELS))  index of the reported channel.
REQ-015 event_level  output  1  current level of event_channel at report time.

Function
REQ-016 Each channel SHALL pass through a 2-flop synchroniser before any other logic.
REQ-017 A prescaler counting 0..SAMPLE_DIV-1 SHALL generate a sample tick on the cycle it equals SAMPLE_DIV-1 and then wrap to 0; with SAMPLE_DIV=1 every cycle is a tick.
REQ-018 On each tick, each channel SHALL shift its synchronised bit into a DEPTH-bit history register.
REQ-019 level[i] SHALL become 1 when all DEPTH history bits are 1, SHALL become 0 when all are 0, and SHALL otherwise hold.
REQ-020 With SAMPLE_DIV=1 and a steady raw change, level SHALL change exactly DEPTH+3 clk cycles after the first clk edge that samples the new raw value.
REQ-021 rise[i] and fall[i] SHALL be high for exactly the one cycle on which level[i] is first observed at its new value; they SHALL never be high together.
REQ-022 Each channel SHALL own a pending bit that is set on any level change.
REQ-023 A pending bit SHALL clear when its change is accepted (event_valid and event_ready high on the same cycle).
REQ-024 If a new level change and acceptance hit the same channel in the same cycle, the pending bit SHALL remain set.
REQ-025 When no report is presented and at least one pending bit is set, the block SHALL load the lowest-index pending channel into event_channel/event_level and assert event_valid on the next cycle.
REQ-026 While event_valid is high and event_ready is low, event_channel and event_level SHALL hold stable.
REQ-027 After acceptance, event_valid SHALL deassert for at least one cycle before the next report is presented.
REQ-028 Multiple changes of one channel before acceptance SHALL coalesce into one report carrying the latest level; no pending change SHALL ever be lost.

Reset
REQ-029 While reset is high, the synchronisers, history registers, level, rise, fall, pending bits, prescaler, event_valid, event_channel and event_level SHALL all be driven to 0.
REQ-030 The first clk edge with reset low SHALL begin sampling; a reset asserted mid-debounce or mid-handshake SHALL discard all in-flight state, with no report emitted for it.
REQ-031 After reset, a raw input already at its active value SHALL raise level through the normal DEPTH-sample path and SHALL produce a rise pulse and an event.

Verification (CHANNELS=4, DEPTH=4, SAMPLE_DIV=1, ACTIVE_LOW=1 unless stated)
REQ-032 Drive raw_in[2] 1->0 and hold -> level[2]=1 after exactly 7 cycles, rise[2] for 1 cycle, event_valid next cycle with channel=2, level=1.
REQ-033 Toggle raw_in[1] every 2 cycles for 40 cycles -> level[1] stays 0; no rise, fall or event.
REQ-034 Activate channels 3 and 0 on the same cycle with event_ready=0 -> report channel 0 held stable; on ready, then channel 3 after at least one idle cycle.
REQ-035 Activate then release channel 1 before acceptance, with ready=0 for 30 cycles -> exactly one report, channel=1, level=0.
REQ-036 SAMPLE_DIV=5, steady change on channel 0 -> level changes exactly 20 cycles after the first tick that samples the new value.
REQ-037 Assert reset for 1 cycle while event_valid=1 -> all outputs 0 on the next cycle; only changes re-detected after reset are reported.
